alu_seq: RTL and testbench

Sequential execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and executes it on two 32-bit operands. Single-cycle ops (add, sub, and, xor, sll, sra) complete in one cycle. `mul` runs as a 32-iteration shift-add sequence. Valid/ready handshakes are provided on both the operand side (from decode/issue) and the result side (to writeback), so the pipeline stalls cleanly during a multiply.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/mul_iter.sv | 57 +++++
 rtl/alu_seq.sv | 114 +++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: width default, control codes, FSM states.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLL = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_SRA = 4'b1101;
  localparam logic [CTRL_W-1:0] ALU_MUL = 4'b1111;

  // EXEC is the one-cycle compute slot that follows operand capture for single-cycle ops.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// Shift-add multiplier: one iteration per cycle, exactly W iterations, low W bits of the product.
module mul_iter #(
  parameter int unsigned W = alu_pkg::XLEN
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(W);

  logic [W-1:0]     acc;
  logic [W-1:0]     multiplicand;
  logic [W-1:0]     multiplier;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     acc_next;

  assign acc_next = acc + (multiplier[0] ? multiplicand : '0);

  // start loads fresh operands and restarts even if an earlier run was in flight
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc          <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      count        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      product      <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc          <= '0;
        multiplicand <= src_a;
        multiplier   <= src_b;
        count        <= '0;
        busy         <= 1'b1;
      end else if (busy) begin
        acc          <= acc_next;
        multiplicand <= multiplicand << 1;
        multiplier   <= multiplier >> 1;
        count        <= count + CNT_W'(1);
        if (count == CNT_W'(W - 1)) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          product <= acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential execution unit: single-cycle ALU ops plus an iterative multiply, valid/ready on both sides.
module alu_seq #(
  parameter int unsigned XLEN = alu_pkg::XLEN
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [alu_pkg::CTRL_W-1:0] aluctr_i,
  input  logic [XLEN-1:0]            src1_i,
  input  logic [XLEN-1:0]            src2_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [XLEN-1:0]            result_o,
  output logic                       zero_o
);

  import alu_pkg::*;

  localparam int unsigned SH_W = $clog2(XLEN);

  state_t            state;
  logic [CTRL_W-1:0] op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   alu_res;
  logic              accept;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [XLEN-1:0]   mul_product;

  assign accept    = (state == ST_IDLE) && valid_i && ready_o;
  assign mul_start = accept && (aluctr_i == ALU_MUL);

  // Single-cycle datapath on the latched request; unknown codes execute as add.
  always_comb begin
    alu_res = a_q + b_q;
    case (op_q)
      ALU_SUB: alu_res = a_q - b_q;
      ALU_AND: alu_res = a_q & b_q;
      ALU_XOR: alu_res = a_q ^ b_q;
      ALU_SLL: alu_res = a_q << b_q[SH_W-1:0];
      ALU_SRA: alu_res = XLEN'($signed(a_q) >>> b_q[SH_W-1:0]);
      default: alu_res = a_q + b_q;
    endcase
  end

  mul_iter #(.W(XLEN)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (mul_start),
    .src_a   (src1_i),
    .src_b   (src2_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // ready_o/valid_o are registered alongside the state so they always match it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      ready_o  <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_o <= 1'b1;
          if (accept) begin
            op_q    <= aluctr_i;
            a_q     <= src1_i;
            b_q     <= src2_i;
            ready_o <= 1'b0;
            state   <= (aluctr_i == ALU_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_o <= alu_res;
          zero_o   <= (alu_res == '0);
          valid_o  <= 1'b1;
          state    <= ST_DONE;
        end
        ST_MUL: begin
          // !busy also releases the FSM should the done pulse ever be missed
          if (mul_done || !mul_busy) begin
            result_o <= mul_product;
            zero_o   <= (mul_product == '0);
            valid_o  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          ready_o <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-written handshake/reset sequences, random ops vs a model.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [3:0]  aluctr;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_seq dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid_in),
    .ready_o  (ready_out),
    .aluctr_i (aluctr),
    .src1_i   (src1),
    .src2_i   (src2),
    .valid_o  (valid_out),
    .ready_i  (ready_in),
    .result_o (result),
    .zero_o   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  // Reference behaviour straight from the operation rules: plain arithmetic, 64-bit product truncated.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op)
      4'b1000: return a - b;
      4'b0111: return a & b;
      4'b0100: return a ^ b;
      4'b0001: return a << sh;
      4'b1101: return $unsigned($signed(a) >>> sh);
      4'b1111: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      default: return a + b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits (bounded) for ready, presents one request, returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    aluctr   = op;
    src1     = a;
    src2     = b;
    @(negedge clk);
    valid_in = 1'b0;
    aluctr   = 4'($urandom);
    src1     = $urandom;
    src2     = $urandom;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!valid_out && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic exp_zero, input int exp_lat);
    int lat;
    send(op, a, b);
    wait_result(lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, result, exp);
    check({name, "_zero"}, 32'(zero), 32'(exp_zero));
    @(negedge clk);
    check({name, "_valid_drop"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;

    vecs[0] = '{"sub_zero",  4'b1000, 32'd5,        32'd5,        32'h0000_0000, 1'b1, 1};
    vecs[1] = '{"sra_neg",   4'b1101, 32'h8000_0000, 32'd4,       32'hF800_0000, 1'b0, 1};
    vecs[2] = '{"sll_wrap",  4'b0001, 32'd1,        32'd33,       32'd2,         1'b0, 1};
    vecs[3] = '{"xor",       4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 1};
    vecs[4] = '{"code_0010", 4'b0010, 32'd3,        32'd4,        32'd7,         1'b0, 1};
    vecs[5] = '{"and",       4'b0111, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1};
    vecs[6] = '{"sub_wrap",  4'b1000, 32'd0,        32'd1,        32'hFFFF_FFFF, 1'b0, 1};
    vecs[7] = '{"mul_neg1",  4'b1111, 32'hFFFF_FFFF, 32'd3,       32'hFFFF_FFFD, 1'b0, 33};
    vecs[8] = '{"mul_big",   4'b1111, 32'd12345,    32'd6789,     32'd83810205,  1'b0, 33};

    rst      = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    aluctr   = '0;
    src1     = '0;
    src2     = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready_out), 32'd0);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", 32'(zero), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(ready_out), 32'd1);

    // add 7+5: result one cycle after acceptance, ready low for exactly two cycles
    send(4'b0000, 32'd7, 32'd5);
    check("add_ready_low1", 32'(ready_out), 32'd0);
    check("add_valid_early", 32'(valid_out), 32'd0);
    @(negedge clk);
    check("add_valid", 32'(valid_out), 32'd1);
    check("add_result", result, 32'd12);
    check("add_zero", 32'(zero), 32'd0);
    check("add_ready_low2", 32'(ready_out), 32'd0);
    @(negedge clk);
    check("add_ready_back", 32'(ready_out), 32'd1);
    check("add_valid_drop", 32'(valid_out), 32'd0);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].exp_zero, vecs[i].exp_lat);

    // Backpressure: result held for 10 cycles, no new request accepted meanwhile
    ready_in = 1'b0;
    send(4'b1111, 32'h0000_1234, 32'h0000_0010);
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd33);
    held = result;
    check("bp_result", held, 32'h0001_2340);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", 32'(valid_out), 32'd1);
      check("bp_result_held", result, 32'h0001_2340);
      check("bp_ready_low", 32'(ready_out), 32'd0);
      if (i == 4) begin
        valid_in = 1'b1;
        aluctr   = 4'b0000;
        src1     = 32'd1;
        src2     = 32'd1;
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(valid_out), 32'd0);
    check("bp_release_ready", 32'(ready_out), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("bp_no_phantom", 32'(valid_out), 32'd0);
    end

    // Reset landing on the counter==15 iteration aborts the multiply
    send(4'b1111, 32'hDEAD_BEEF, 32'h0000_0777);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready_out), 32'd0);
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", 32'(zero), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", 32'(ready_out), 32'd1);
    run_op("post_rst_add", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 1);

    // Random requests against the model, with occasional consumer stalls
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      e  = model(op, a, b);
      ready_in = ($urandom_range(0, 2) != 0);
      send(op, a, b);
      wait_result(lat);
      check("rnd_latency", 32'(lat), (op == 4'b1111) ? 32'd33 : 32'd1);
      check("rnd_result", result, e);
      check("rnd_zero", 32'(zero), 32'(e == 32'd0));
      if (!ready_in) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("rnd_stall_result", result, e);
        check("rnd_stall_valid", 32'(valid_out), 32'd1);
        ready_in = 1'b1;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
